// File: rtl/mips_cpu_pkg.sv
// Shared register-file constants and destination-select types for the MIPS decode/writeback path.
package mips_cpu_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   // DEST_LINK stands for 2'b1x: select[1] alone decides the link case
   typedef enum logic [1:0] {
      DEST_RT   = 2'b00,
      DEST_RD   = 2'b01,
      DEST_LINK = 2'b10
   } dest_sel_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] addr;
   } dest_entry_t;

endpackage

// File: rtl/mips_cpu_dest_match.sv
// Compares one source register against the in-flight destination vector (stage 0 = youngest).
// With MIPS_CPU_DEST_FWD_EN defined it also returns the youngest-match forwarding index.
module mips_cpu_dest_match
   import mips_cpu_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int STAGES = 3
) (
   input  logic [ADDR_W-1:0]        i_src,
   input  logic [STAGES-1:0]        i_valid,
   input  logic [STAGES*ADDR_W-1:0] i_addr,
   output logic                     o_hit
`ifdef MIPS_CPU_DEST_FWD_EN
   ,output logic [$clog2(STAGES+1)-1:0] o_sel
`endif
);

   localparam int CNT_W = $clog2(STAGES + 1);

   logic w_src_nz;

   assign w_src_nz = (i_src != ADDR_W'(REG_ZERO));

   // The final stage is left out: the register file writes before it is read
   always_comb begin
      o_hit = 1'b0;
      for (int unsigned k = 0; k + 1 < STAGES; k++) begin
         if (i_valid[k] && (i_addr[k*ADDR_W +: ADDR_W] == i_src)) begin
            o_hit = 1'b1;
         end
      end
      o_hit = o_hit & w_src_nz;
   end

`ifdef MIPS_CPU_DEST_FWD_EN
   // Scan oldest to youngest so the youngest match is the one left standing
   always_comb begin
      o_sel = '0;
      for (int unsigned k = STAGES; k > 0; k--) begin
         if (w_src_nz && i_valid[k-1] && (i_addr[(k-1)*ADDR_W +: ADDR_W] == i_src)) begin
            o_sel = CNT_W'(k);
         end
      end
   end
`endif

endmodule

// File: rtl/mips_cpu_dest_pipe.sv
// Destination register select plus valid/address pipeline to writeback, with RAW hazard detect.
// Optional forwarding-select outputs are enabled by defining MIPS_CPU_DEST_FWD_EN.
module mips_cpu_dest_pipe
   import mips_cpu_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int STAGES   = 3,
   parameter int LINK_REG = 31
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [ADDR_W-1:0]            rt,
   input  logic [ADDR_W-1:0]            rd,
   input  logic [1:0]                   select,
   input  logic                         issue_valid,
   input  logic                         reg_write,
   input  logic                         stall,
   input  logic                         flush,
   input  logic [ADDR_W-1:0]            rs_src,
   input  logic [ADDR_W-1:0]            rt_src,
   output logic                         wb_valid,
   output logic [ADDR_W-1:0]            wb_addr,
   output logic                         hazard_rs,
   output logic                         hazard_rt,
   output logic [$clog2(STAGES+1)-1:0]  inflight_count
`ifdef MIPS_CPU_DEST_FWD_EN
   ,output logic [$clog2(STAGES+1)-1:0] fwd_rs_sel,
   output logic [$clog2(STAGES+1)-1:0]  fwd_rt_sel
`endif
);

   localparam int CNT_W = $clog2(STAGES + 1);

   // Width-parametrised counterpart of dest_entry_t
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
   } stage_t;

   stage_t                    r_stage [STAGES];
   stage_t                    w_entry;
   logic [ADDR_W-1:0]         w_dest;
   logic [STAGES-1:0]         w_valid_vec;
   logic [STAGES*ADDR_W-1:0]  w_addr_vec;
   logic [CNT_W-1:0]          w_count;

   always_comb begin
      w_dest = rt;
      if (select[1]) begin
         w_dest = ADDR_W'(LINK_REG);
      end else if (dest_sel_t'(select) == DEST_RD) begin
         w_dest = rd;
      end
   end

   assign w_entry.valid = issue_valid & reg_write & (w_dest != ADDR_W'(REG_ZERO));
   assign w_entry.addr  = w_dest;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_stage[k] <= '0;
         end
      end else if (flush) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_stage[k].valid <= 1'b0;
         end
      end else if (!stall) begin
         for (int unsigned k = STAGES - 1; k > 0; k--) begin
            r_stage[k] <= r_stage[k-1];
         end
         r_stage[0] <= w_entry;
      end
   end

   always_comb begin
      w_valid_vec = '0;
      w_addr_vec  = '0;
      w_count     = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         w_valid_vec[k]                  = r_stage[k].valid;
         w_addr_vec[k*ADDR_W +: ADDR_W]  = r_stage[k].addr;
         w_count                         = w_count + CNT_W'(r_stage[k].valid);
      end
   end

   assign wb_valid       = r_stage[STAGES-1].valid;
   assign wb_addr        = r_stage[STAGES-1].addr;
   assign inflight_count = w_count;

   mips_cpu_dest_match #(
      .ADDR_W (ADDR_W),
      .STAGES (STAGES)
   ) u_match_rs (
      .i_src   (rs_src),
      .i_valid (w_valid_vec),
      .i_addr  (w_addr_vec),
      .o_hit   (hazard_rs)
`ifdef MIPS_CPU_DEST_FWD_EN
      ,.o_sel  (fwd_rs_sel)
`endif
   );

   mips_cpu_dest_match #(
      .ADDR_W (ADDR_W),
      .STAGES (STAGES)
   ) u_match_rt (
      .i_src   (rt_src),
      .i_valid (w_valid_vec),
      .i_addr  (w_addr_vec),
      .o_hit   (hazard_rt)
`ifdef MIPS_CPU_DEST_FWD_EN
      ,.o_sel  (fwd_rt_sel)
`endif
   );

endmodule

// File: tb/tb_mips_cpu_dest_pipe.sv
// Self-checking bench for mips_cpu_dest_pipe (STAGES=3): vector table with scoreboard, plus hand sequences.
// Defining MIPS_CPU_DEST_FWD_EN also checks the forwarding-select outputs.
module tb_mips_cpu_dest_pipe;

   localparam int ADDR_W = 5;
   localparam int STAGES = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rt, rd, rs_src, rt_src;
   logic [1:0]  select;
   logic        issue_valid, reg_write, stall, flush;
   logic        wb_valid, hazard_rs, hazard_rt;
   logic [4:0]  wb_addr;
   logic [1:0]  inflight_count;
`ifdef MIPS_CPU_DEST_FWD_EN
   logic [1:0]  fwd_rs_sel, fwd_rt_sel;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mips_cpu_dest_pipe #(
      .ADDR_W   (ADDR_W),
      .STAGES   (STAGES),
      .LINK_REG (31)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rt             (rt),
      .rd             (rd),
      .select         (select),
      .issue_valid    (issue_valid),
      .reg_write      (reg_write),
      .stall          (stall),
      .flush          (flush),
      .rs_src         (rs_src),
      .rt_src         (rt_src),
      .wb_valid       (wb_valid),
      .wb_addr        (wb_addr),
      .hazard_rs      (hazard_rs),
      .hazard_rt      (hazard_rt),
      .inflight_count (inflight_count)
`ifdef MIPS_CPU_DEST_FWD_EN
      ,.fwd_rs_sel    (fwd_rs_sel),
      .fwd_rt_sel     (fwd_rt_sel)
`endif
   );

   typedef struct {
      logic [4:0] rt;
      logic [4:0] rd;
      logic [1:0] sel;
      logic       issue;
      logic       rw;
      logic       exp_v;
      logic [4:0] exp_a;
   } vec_t;

   typedef struct {
      logic       v;
      logic [4:0] a;
   } exp_t;

   vec_t vecs [12];
   exp_t sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] i_rt, input logic [4:0] i_rd, input logic [1:0] i_sel,
                        input logic i_issue, input logic i_rw);
      rt          = i_rt;
      rd          = i_rd;
      select      = i_sel;
      issue_valid = i_issue;
      reg_write   = i_rw;
   endtask

   initial begin
      exp_t e;
      int   cnt;

      // rt, rd, sel, issue, reg_write, expected wb valid, expected wb addr
      vecs[0]  = '{5'd8,  5'd9,  2'b00, 1'b1, 1'b1, 1'b1, 5'd8};
      vecs[1]  = '{5'd8,  5'd9,  2'b01, 1'b1, 1'b1, 1'b1, 5'd9};
      vecs[2]  = '{5'd8,  5'd9,  2'b10, 1'b1, 1'b1, 1'b1, 5'd31};
      vecs[3]  = '{5'd8,  5'd9,  2'b11, 1'b1, 1'b1, 1'b1, 5'd31};
      vecs[4]  = '{5'd0,  5'd9,  2'b00, 1'b1, 1'b1, 1'b0, 5'd0};
      vecs[5]  = '{5'd3,  5'd0,  2'b01, 1'b1, 1'b1, 1'b0, 5'd0};
      vecs[6]  = '{5'd12, 5'd13, 2'b00, 1'b1, 1'b0, 1'b0, 5'd12};
      vecs[7]  = '{5'd14, 5'd15, 2'b01, 1'b0, 1'b1, 1'b0, 5'd15};
      vecs[8]  = '{5'd20, 5'd21, 2'b00, 1'b1, 1'b1, 1'b1, 5'd20};
      vecs[9]  = '{5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 5'd0};
      vecs[10] = '{5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 5'd0};
      vecs[11] = '{5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 1'b0, 5'd0};

      rst_n  = 1'b0;
      drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      stall  = 1'b0;
      flush  = 1'b0;
      rs_src = 5'd0;
      rt_src = 5'd0;

      // Reset held, then idle
      repeat (3) @(posedge clk);
      #1;
      check("rst_wb_valid", 32'(wb_valid), 0);
      check("rst_wb_addr", 32'(wb_addr), 0);
      check("rst_hazard_rs", 32'(hazard_rs), 0);
      check("rst_hazard_rt", 32'(hazard_rt), 0);
      check("rst_inflight", 32'(inflight_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_inflight", 32'(inflight_count), 0);
         check("idle_wb_valid", 32'(wb_valid), 0);
      end

      // Table vectors through the scoreboard; prefill models the two idle stages ahead of the first issue
      sb.delete();
      sb.push_back('{1'b0, 5'd0});
      sb.push_back('{1'b0, 5'd0});
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].rt, vecs[i].rd, vecs[i].sel, vecs[i].issue, vecs[i].rw);
         tick();
         sb.push_back('{vecs[i].exp_v, vecs[i].exp_a});
         cnt = 0;
         foreach (sb[j]) cnt += int'(sb[j].v);
         e = sb.pop_front();
         check("tbl_wb_valid", 32'(wb_valid), 32'(e.v));
         check("tbl_wb_addr", 32'(wb_addr), 32'(e.a));
         check("tbl_inflight", 32'(inflight_count), 32'(cnt));
         check("tbl_hazard_rs_zero", 32'(hazard_rs), 0);
      end
      sb.delete();

      // Hazard window for dest 5
      drive(5'd5, 5'd0, 2'b00, 1'b1, 1'b1);
      rs_src = 5'd5;
      rt_src = 5'd6;
      #1;
      check("haz_issue_not_self", 32'(hazard_rs), 0);
      tick();
      drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      check("haz_s0_rs", 32'(hazard_rs), 1);
      check("haz_s0_rt", 32'(hazard_rt), 0);
      rs_src = 5'd0;
      #1;
      check("haz_rs_zero", 32'(hazard_rs), 0);
      rs_src = 5'd5;
      tick();
      check("haz_s1_rs", 32'(hazard_rs), 1);
      check("haz_s1_wb_valid", 32'(wb_valid), 0);
      tick();
      check("haz_final_rs", 32'(hazard_rs), 0);
      check("haz_final_wb_valid", 32'(wb_valid), 1);
      check("haz_final_wb_addr", 32'(wb_addr), 5);
      check("haz_final_inflight", 32'(inflight_count), 1);
      tick();
      check("haz_drain_wb_valid", 32'(wb_valid), 0);
      check("haz_drain_inflight", 32'(inflight_count), 0);

      // Stall then flush+stall
      rs_src = 5'd0;
      rt_src = 5'd0;
      drive(5'd3, 5'd0, 2'b00, 1'b1, 1'b1);
      tick();
      drive(5'd4, 5'd0, 2'b00, 1'b1, 1'b1);
      tick();
      drive(5'd7, 5'd0, 2'b00, 1'b1, 1'b1);
      tick();
      check("stl_pre_wb_addr", 32'(wb_addr), 3);
      check("stl_pre_inflight", 32'(inflight_count), 3);
      drive(5'd10, 5'd0, 2'b00, 1'b1, 1'b1);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("stl_wb_valid", 32'(wb_valid), 1);
         check("stl_wb_addr", 32'(wb_addr), 3);
         check("stl_inflight", 32'(inflight_count), 3);
      end
      rs_src = 5'd4;
      rt_src = 5'd7;
      #1;
      check("stl_hazard_rs_mid", 32'(hazard_rs), 1);
      check("stl_hazard_rt_young", 32'(hazard_rt), 1);
`ifdef MIPS_CPU_DEST_FWD_EN
      check("stl_fwd_rs", 32'(fwd_rs_sel), 2);
      check("stl_fwd_rt", 32'(fwd_rt_sel), 1);
`endif
      rs_src = 5'd3;
      #1;
      check("stl_hazard_rs_final", 32'(hazard_rs), 0);
`ifdef MIPS_CPU_DEST_FWD_EN
      check("stl_fwd_rs_final", 32'(fwd_rs_sel), 3);
`endif
      flush = 1'b1;
      tick();
      check("fl_inflight", 32'(inflight_count), 0);
      check("fl_wb_valid", 32'(wb_valid), 0);
      check("fl_hazard_rt", 32'(hazard_rt), 0);
      flush = 1'b0;
      stall = 1'b0;
      rs_src = 5'd0;
      rt_src = 5'd0;
      drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      tick();
      check("fl_after_inflight", 32'(inflight_count), 0);

      // Asynchronous reset between edges
      drive(5'd11, 5'd0, 2'b00, 1'b1, 1'b1);
      tick();
      drive(5'd12, 5'd0, 2'b00, 1'b1, 1'b1);
      tick();
      drive(5'd13, 5'd0, 2'b00, 1'b1, 1'b1);
      tick();
      drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
      check("ar_pre_inflight", 32'(inflight_count), 3);
      check("ar_pre_wb_addr", 32'(wb_addr), 11);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_wb_valid", 32'(wb_valid), 0);
      check("ar_wb_addr", 32'(wb_addr), 0);
      check("ar_inflight", 32'(inflight_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("ar_post_inflight", 32'(inflight_count), 0);
      check("ar_post_wb_valid", 32'(wb_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
